sdram_arbiter: RTL and testbench

Sequencer and arbiter for the SDR SDRAM command bus. It holds the bus for the init engine until init completes. After that it grants the bus to exactly one of the auto-refresh, write or read engines at a time. Arbitration is fixed priority for refresh and round-robin between write and read. The selected engine's cmd/ba/addr drive the SDRAM pins, and a watchdog recovers the bus from a hung engine.

---
 rtl/sdram_arbiter_if.sv | 58 +++++
 rtl/sdram_arbiter.sv | 146 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_if.sv
// Bus bundle between the SDRAM command engines, the arbiter and the SDRAM pins.
// The arbiter takes the slave modport; the engines/pins side takes master.
interface sdram_arbiter_if;
  logic        init_end_i;
  logic [3:0]  init_cmd_i;
  logic [1:0]  init_ba_i;
  logic [12:0] init_addr_i;

  logic        aref_req_i;
  logic        aref_end_i;
  logic [3:0]  aref_cmd_i;
  logic [1:0]  aref_ba_i;
  logic [12:0] aref_addr_i;

  logic        wr_req_i;
  logic        wr_end_i;
  logic [3:0]  wr_cmd_i;
  logic [1:0]  wr_ba_i;
  logic [12:0] wr_addr_i;

  logic        rd_req_i;
  logic        rd_end_i;
  logic [3:0]  rd_cmd_i;
  logic [1:0]  rd_ba_i;
  logic [12:0] rd_addr_i;

  logic        aref_en_o;
  logic        wr_en_o;
  logic        rd_en_o;
  logic        sdram_cke_o;
  logic        sdram_cs_n_o;
  logic        sdram_ras_n_o;
  logic        sdram_cas_n_o;
  logic        sdram_we_n_o;
  logic [1:0]  sdram_ba_o;
  logic [12:0] sdram_addr_o;
  logic        timeout_o;

  modport slave (
    input  init_end_i, init_cmd_i, init_ba_i, init_addr_i,
    input  aref_req_i, aref_end_i, aref_cmd_i, aref_ba_i, aref_addr_i,
    input  wr_req_i, wr_end_i, wr_cmd_i, wr_ba_i, wr_addr_i,
    input  rd_req_i, rd_end_i, rd_cmd_i, rd_ba_i, rd_addr_i,
    output aref_en_o, wr_en_o, rd_en_o, sdram_cke_o,
    output sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o,
    output sdram_ba_o, sdram_addr_o, timeout_o
  );

  modport master (
    output init_end_i, init_cmd_i, init_ba_i, init_addr_i,
    output aref_req_i, aref_end_i, aref_cmd_i, aref_ba_i, aref_addr_i,
    output wr_req_i, wr_end_i, wr_cmd_i, wr_ba_i, wr_addr_i,
    output rd_req_i, rd_end_i, rd_cmd_i, rd_ba_i, rd_addr_i,
    input  aref_en_o, wr_en_o, rd_en_o, sdram_cke_o,
    input  sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o,
    input  sdram_ba_o, sdram_addr_o, timeout_o
  );
endinterface

// File: rtl/sdram_arbiter.sv
// SDRAM command-bus sequencer: init ownership, then refresh-first arbitration
// with write/read round-robin, a command mux and a hung-engine watchdog.
module sdram_arbiter #(
  parameter int TIMEOUT_MAX = 1023,
  parameter int CNT_W       = 10
) (
  input  logic            sys_clk_i,
  input  logic            rst_i,
  sdram_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARB   = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_t;

  localparam logic [3:0]  CMD_NOP   = 4'b0111;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_MAX);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // last_wr_q=1 means the most recent read/write grant was a write.
  logic             last_wr_q, last_wr_d;
  logic             timeout_q, timeout_d;
  logic             end_sel;

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      last_wr_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_wr_q <= last_wr_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    end_sel = 1'b0;
    case (state_q)
      ST_AREF:  end_sel = bus.aref_end_i;
      ST_WRITE: end_sel = bus.wr_end_i;
      ST_READ:  end_sel = bus.rd_end_i;
      default:  end_sel = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    last_wr_d = last_wr_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (bus.init_end_i) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (bus.aref_req_i) begin
          state_d = ST_AREF;
        end else if (bus.wr_req_i && bus.rd_req_i) begin
          if (last_wr_q) begin
            state_d   = ST_READ;
            last_wr_d = 1'b0;
          end else begin
            state_d   = ST_WRITE;
            last_wr_d = 1'b1;
          end
        end else if (bus.wr_req_i) begin
          state_d   = ST_WRITE;
          last_wr_d = 1'b1;
        end else if (bus.rd_req_i) begin
          state_d   = ST_READ;
          last_wr_d = 1'b0;
        end
      end
      ST_AREF, ST_WRITE, ST_READ: begin
        // A completion coinciding with expiry wins: no timeout pulse.
        if (end_sel) begin
          state_d = ST_ARB;
        end else if (cnt_q == CNT_LIMIT) begin
          state_d   = ST_ARB;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  logic [3:0]  cmd_mux;
  logic [1:0]  ba_mux;
  logic [12:0] addr_mux;

  always_comb begin
    cmd_mux  = CMD_NOP;
    ba_mux   = 2'b11;
    addr_mux = 13'h1FFF;
    case (state_q)
      ST_INIT: begin
        cmd_mux  = bus.init_cmd_i;
        ba_mux   = bus.init_ba_i;
        addr_mux = bus.init_addr_i;
      end
      ST_AREF: begin
        cmd_mux  = bus.aref_cmd_i;
        ba_mux   = bus.aref_ba_i;
        addr_mux = bus.aref_addr_i;
      end
      ST_WRITE: begin
        cmd_mux  = bus.wr_cmd_i;
        ba_mux   = bus.wr_ba_i;
        addr_mux = bus.wr_addr_i;
      end
      ST_READ: begin
        cmd_mux  = bus.rd_cmd_i;
        ba_mux   = bus.rd_ba_i;
        addr_mux = bus.rd_addr_i;
      end
      default: begin
        cmd_mux  = CMD_NOP;
        ba_mux   = 2'b11;
        addr_mux = 13'h1FFF;
      end
    endcase
  end

  assign bus.aref_en_o     = (state_q == ST_AREF);
  assign bus.wr_en_o       = (state_q == ST_WRITE);
  assign bus.rd_en_o       = (state_q == ST_READ);
  assign bus.timeout_o     = timeout_q;
  assign bus.sdram_cke_o   = 1'b1;
  assign bus.sdram_cs_n_o  = cmd_mux[3];
  assign bus.sdram_ras_n_o = cmd_mux[2];
  assign bus.sdram_cas_n_o = cmd_mux[1];
  assign bus.sdram_we_n_o  = cmd_mux[0];
  assign bus.sdram_ba_o    = ba_mux;
  assign bus.sdram_addr_o  = addr_mux;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: init handoff, round-robin, refresh priority,
// watchdog expiry, end-at-expiry and reset during a burst.
module tb_sdram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sdram_arbiter_if bus_if ();

  sdram_arbiter #(.TIMEOUT_MAX(15), .CNT_W(4)) dut (
    .sys_clk_i (clk),
    .rst_i     (rst),
    .bus       (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Grants as {aref_en, wr_en, rd_en}.
  task automatic chk_grant(input string tag, input logic [2:0] exp);
    check(tag, {29'd0, bus_if.aref_en_o, bus_if.wr_en_o, bus_if.rd_en_o}, {29'd0, exp});
  endtask

  task automatic chk_bus(input string tag, input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
    check(tag, {13'd0, bus_if.sdram_cs_n_o, bus_if.sdram_ras_n_o, bus_if.sdram_cas_n_o,
                bus_if.sdram_we_n_o, bus_if.sdram_ba_o, bus_if.sdram_addr_o},
               {13'd0, c, b, a});
  endtask

  task automatic pulse_wr_end();
    bus_if.wr_end_i = 1'b1; tick(); bus_if.wr_end_i = 1'b0;
  endtask
  task automatic pulse_rd_end();
    bus_if.rd_end_i = 1'b1; tick(); bus_if.rd_end_i = 1'b0;
  endtask

  initial begin
    bus_if.init_end_i = 1'b0; bus_if.init_cmd_i = 4'hA; bus_if.init_ba_i = 2'd1; bus_if.init_addr_i = 13'h0123;
    bus_if.aref_req_i = 1'b0; bus_if.aref_end_i = 1'b0;
    bus_if.aref_cmd_i = 4'h1; bus_if.aref_ba_i = 2'd0; bus_if.aref_addr_i = 13'h0400;
    bus_if.wr_req_i = 1'b0; bus_if.wr_end_i = 1'b0;
    bus_if.wr_cmd_i = 4'h4; bus_if.wr_ba_i = 2'd1; bus_if.wr_addr_i = 13'h0AAA;
    bus_if.rd_req_i = 1'b0; bus_if.rd_end_i = 1'b0;
    bus_if.rd_cmd_i = 4'h5; bus_if.rd_ba_i = 2'd2; bus_if.rd_addr_i = 13'h0555;

    // Reset and INIT passthrough
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk_grant("reset_grants", 3'b000);
    check("reset_timeout", {31'd0, bus_if.timeout_o}, 32'd0);
    check("cke", {31'd0, bus_if.sdram_cke_o}, 32'd1);
    chk_bus("init_bus_a", 4'hA, 2'd1, 13'h0123);
    for (int i = 0; i < 17; i++) tick();
    bus_if.init_cmd_i = 4'h2; bus_if.init_ba_i = 2'd2; bus_if.init_addr_i = 13'h1234;
    #1;
    chk_bus("init_bus_b", 4'h2, 2'd2, 13'h1234);
    bus_if.init_end_i = 1'b1; tick();
    chk_bus("arb_nop", 4'b0111, 2'b11, 13'h1FFF);
    chk_grant("arb_idle", 3'b000);
    tick();
    chk_grant("arb_stays_idle", 3'b000);

    // Contended write/read alternate, starting with WRITE
    bus_if.wr_req_i = 1'b1; bus_if.rd_req_i = 1'b1; tick();
    chk_grant("rr_write1", 3'b010);
    chk_bus("wr_bus", 4'h4, 2'd1, 13'h0AAA);
    pulse_rd_end();
    chk_grant("ignore_rd_end", 3'b010);
    pulse_wr_end();
    chk_grant("gap_after_wr", 3'b000);
    chk_bus("gap_nop", 4'b0111, 2'b11, 13'h1FFF);
    tick();
    chk_grant("rr_read1", 3'b001);
    chk_bus("rd_bus", 4'h5, 2'd2, 13'h0555);
    pulse_rd_end();
    chk_grant("gap_after_rd", 3'b000);
    tick();
    chk_grant("rr_write2", 3'b010);

    // Refresh raised mid-write is served before the pending read
    bus_if.aref_req_i = 1'b1; tick();
    chk_grant("no_preempt", 3'b010);
    pulse_wr_end();
    chk_grant("gap_before_aref", 3'b000);
    tick();
    chk_grant("aref_grant", 3'b100);
    chk_bus("aref_bus", 4'h1, 2'd0, 13'h0400);
    bus_if.aref_req_i = 1'b0; bus_if.aref_end_i = 1'b1; tick(); bus_if.aref_end_i = 1'b0;
    chk_grant("gap_after_aref", 3'b000);
    tick();
    chk_grant("read_after_aref", 3'b001);

    // Watchdog: read never ends; 16 cycles in READ then timeout pulse
    bus_if.wr_req_i = 1'b0; bus_if.rd_req_i = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk_grant("read_cycle16", 3'b001);
    check("no_timeout_yet", {31'd0, bus_if.timeout_o}, 32'd0);
    tick();
    chk_grant("wd_drop", 3'b000);
    check("timeout_pulse", {31'd0, bus_if.timeout_o}, 32'd1);
    chk_bus("wd_nop", 4'b0111, 2'b11, 13'h1FFF);
    tick();
    check("timeout_one_cycle", {31'd0, bus_if.timeout_o}, 32'd0);

    // End pulse coincides with expiry: normal completion
    bus_if.rd_req_i = 1'b1; tick(); bus_if.rd_req_i = 1'b0;
    chk_grant("read_again", 3'b001);
    for (int i = 0; i < 15; i++) tick();
    chk_grant("read_at_limit", 3'b001);
    pulse_rd_end();
    chk_grant("end_at_expiry", 3'b000);
    check("end_at_expiry_no_to", {31'd0, bus_if.timeout_o}, 32'd0);
    tick();
    check("end_at_expiry_quiet", {31'd0, bus_if.timeout_o}, 32'd0);

    // Reset during a write burst
    bus_if.wr_req_i = 1'b1; tick(); bus_if.wr_req_i = 1'b0;
    chk_grant("pre_reset_write", 3'b010);
    rst = 1'b1; tick();
    chk_grant("reset_mid_burst", 3'b000);
    chk_bus("reset_init_bus", 4'h2, 2'd2, 13'h1234);
    rst = 1'b0; bus_if.wr_req_i = 1'b1; bus_if.rd_req_i = 1'b1; tick();
    chk_grant("post_reset_arb", 3'b000);
    tick();
    chk_grant("post_reset_write_first", 3'b010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout observed=hang expected=finish");
    $fatal(1, "bench time limit");
  end
endmodule
